// File: rtl/nw_pkg.sv
// nw_pkg: shared states and score width for the Needleman-Wunsch datapath.
package nw_pkg;
  localparam int SCORE_W = 9;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
endpackage

// File: rtl/nw_score_capture_if.sv
// nw_score_capture_if: cell stream in, captured score out.
interface nw_score_capture_if #(parameter int SCORE_W = nw_pkg::SCORE_W);
  logic start, cell_valid, cell_ready, score_valid, busy, error;
  logic signed [SCORE_W-1:0] cell_score, submit_value;
  modport master(output start, cell_valid, cell_score,
                 input cell_ready, submit_value, score_valid, busy, error);
  modport slave(input start, cell_valid, cell_score,
                output cell_ready, submit_value, score_valid, busy, error);
endinterface

// File: rtl/nw_cell_counter.sv
// nw_cell_counter: row-major row/col counter over an N x N matrix with last-cell flag.
module nw_cell_counter #(parameter int N = 5) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic last
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] M = W'(N - 1);
  logic [W-1:0] row, col;
  assign last = row == M && col == M;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      col <= col == M ? '0 : col + 1'b1;
      if (col == M) row <= row + 1'b1;
    end
endmodule

// File: rtl/nw_score_capture.sv
// nw_score_capture: latches the final NW cell score; SCORE_CLAMP_EN saturates it to [-N,+N].
module nw_score_capture import nw_pkg::*; #(
  parameter int N       = 5,
  parameter int SCORE_W = nw_pkg::SCORE_W
) (
  input logic               clk,
  input logic               rst,
  nw_score_capture_if.slave bus
);
  state_t state;
  logic hs, last;
  logic signed [SCORE_W-1:0] cap;
  assign bus.cell_ready = state == COLLECT;
  assign bus.busy       = state == COLLECT;
  // start beats a simultaneous handshake, so the cell is dropped
  assign hs = bus.cell_valid & bus.cell_ready & ~bus.start;
`ifdef SCORE_CLAMP_EN
  localparam logic signed [SCORE_W-1:0] LIM = SCORE_W'(N);
  assign cap = bus.cell_score > LIM ? LIM : bus.cell_score < -LIM ? -LIM : bus.cell_score;
`else
  assign cap = bus.cell_score;
`endif
  nw_cell_counter #(.N(N)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hs),
    .clr (bus.start | (hs & last)),
    .last(last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state            <= IDLE;
      bus.submit_value <= '0;
      bus.score_valid  <= 1'b0;
      bus.error        <= 1'b0;
    end else if (bus.start) begin
      state           <= COLLECT;
      bus.score_valid <= 1'b0;
      bus.error       <= 1'b0;
    end else begin
      if (hs && last) begin
        state            <= HOLD;
        bus.submit_value <= cap;
        bus.score_valid  <= 1'b1;
      end
      if (bus.cell_valid && state != COLLECT) bus.error <= 1'b1;
    end
endmodule

// File: tb/tb_nw_score_capture.sv
// tb_nw_score_capture: directed checks of capture, backpressure, restart, errors, clamp.
module tb_nw_score_capture;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  nw_score_capture_if #(.SCORE_W(9)) bus ();
  nw_score_capture #(.N(5), .SCORE_W(9)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    bus.start = 1;
    step;
    bus.start = 0;
  endtask

  task automatic push(input logic signed [8:0] v);
    int t = 0;
    bus.cell_valid = 1;
    bus.cell_score = v;
    while (!bus.cell_ready && t < 100) begin
      step;
      t++;
    end
    checks++;
    if (!bus.cell_ready) begin
      failures++;
      $display("FAIL push_timeout: cell_ready=%0b required 1", bus.cell_ready);
    end
    step;
    bus.cell_valid = 0;
  endtask

  task automatic cells(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      push(9'(i * 3 - 20));
      if (gap) step;
    end
  endtask

  task automatic test_reset;
    bus.start = 0;
    bus.cell_valid = 0;
    bus.cell_score = 0;
    step;
    step;
    checks++;
    if ({bus.cell_ready, bus.busy, bus.score_valid, bus.error} !== 4'b0 || bus.submit_value !== 9'sd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%0b busy=%0b sv=%0b err=%0b val=%0d required all 0",
               bus.cell_ready, bus.busy, bus.score_valid, bus.error, bus.submit_value);
    end
    #2 rst = 0;
    step;
  endtask

  task automatic test_full_run;
    pulse_start;
    checks++;
    if (bus.cell_ready !== 1 || bus.busy !== 1) begin
      failures++;
      $display("FAIL start_ready: rdy=%0b busy=%0b required 1 1", bus.cell_ready, bus.busy);
    end
    cells(24, 0);
    checks++;
    if (bus.score_valid !== 0 || bus.busy !== 1) begin
      failures++;
      $display("FAIL early_capture: sv=%0b busy=%0b required 0 1", bus.score_valid, bus.busy);
    end
    push(9'sd3);
    checks++;
    if (bus.submit_value !== 9'sd3 || bus.score_valid !== 1) begin
      failures++;
      $display("FAIL full_run: val=%0d sv=%0b required 3 1", bus.submit_value, bus.score_valid);
    end
    checks++;
    if (bus.busy !== 0 || bus.cell_ready !== 0) begin
      failures++;
      $display("FAIL hold_idle: busy=%0b rdy=%0b required 0 0", bus.busy, bus.cell_ready);
    end
    step;
    step;
    checks++;
    if (bus.submit_value !== 9'sd3 || bus.score_valid !== 1) begin
      failures++;
      $display("FAIL hold_stable: val=%0d sv=%0b required 3 1", bus.submit_value, bus.score_valid);
    end
  endtask

  task automatic test_reset_mid_run;
    pulse_start;
    cells(3, 0);
    rst = 1;
    #1;
    checks++;
    if ({bus.cell_ready, bus.busy, bus.score_valid, bus.error} !== 4'b0 || bus.submit_value !== 9'sd0) begin
      failures++;
      $display("FAIL reset_mid_run: rdy=%0b busy=%0b sv=%0b err=%0b val=%0d required all 0",
               bus.cell_ready, bus.busy, bus.score_valid, bus.error, bus.submit_value);
    end
    step;
    #2 rst = 0;
    step;
  endtask

  task automatic test_backpressure;
    pulse_start;
    cells(24, 1);
    checks++;
    if (bus.score_valid !== 0) begin
      failures++;
      $display("FAIL bp_early: sv=%0b required 0", bus.score_valid);
    end
    push(9'sd2);
    checks++;
    if (bus.submit_value !== 9'sd2 || bus.score_valid !== 1) begin
      failures++;
      $display("FAIL backpressure: val=%0d sv=%0b required 2 1", bus.submit_value, bus.score_valid);
    end
  endtask

  task automatic test_restart;
    pulse_start;
    checks++;
    if (bus.score_valid !== 0 || bus.submit_value !== 9'sd2 || bus.busy !== 1) begin
      failures++;
      $display("FAIL restart: sv=%0b val=%0d busy=%0b required 0 2 1", bus.score_valid, bus.submit_value, bus.busy);
    end
    cells(24, 0);
    push(-9'sd4);
    checks++;
    if (bus.submit_value !== -9'sd4 || bus.score_valid !== 1) begin
      failures++;
      $display("FAIL restart_run: val=%0d sv=%0b required -4 1", bus.submit_value, bus.score_valid);
    end
  endtask

  task automatic test_error;
    bus.cell_valid = 1;
    bus.cell_score = 9'sd7;
    step;
    bus.cell_valid = 0;
    checks++;
    if (bus.error !== 1 || bus.cell_ready !== 0) begin
      failures++;
      $display("FAIL error_set: err=%0b rdy=%0b required 1 0", bus.error, bus.cell_ready);
    end
    step;
    step;
    checks++;
    if (bus.error !== 1 || bus.submit_value !== -9'sd4) begin
      failures++;
      $display("FAIL error_sticky: err=%0b val=%0d required 1 -4", bus.error, bus.submit_value);
    end
    pulse_start;
    checks++;
    if (bus.error !== 0) begin
      failures++;
      $display("FAIL error_clear: err=%0b required 0", bus.error);
    end
    cells(10, 0);
    bus.start = 1;
    bus.cell_valid = 1;
    bus.cell_score = 9'sd99;
    step;
    bus.start = 0;
    bus.cell_valid = 0;
    cells(24, 0);
    checks++;
    if (bus.score_valid !== 0 || bus.busy !== 1) begin
      failures++;
      $display("FAIL abort_count: sv=%0b busy=%0b required 0 1", bus.score_valid, bus.busy);
    end
    push(9'sd1);
    checks++;
    if (bus.submit_value !== 9'sd1 || bus.score_valid !== 1 || bus.error !== 0) begin
      failures++;
      $display("FAIL abort_run: val=%0d sv=%0b err=%0b required 1 1 0", bus.submit_value, bus.score_valid, bus.error);
    end
  endtask

  task automatic test_clamp;
    logic signed [8:0] exp_hi, exp_lo;
`ifdef SCORE_CLAMP_EN
    exp_hi = 9'sd5;
    exp_lo = -9'sd5;
`else
    exp_hi = 9'sd9;
    exp_lo = -9'sd12;
`endif
    pulse_start;
    cells(24, 0);
    push(9'sd9);
    checks++;
    if (bus.submit_value !== exp_hi) begin
      failures++;
      $display("FAIL clamp_hi: val=%0d required %0d", bus.submit_value, exp_hi);
    end
    pulse_start;
    cells(24, 0);
    push(-9'sd12);
    checks++;
    if (bus.submit_value !== exp_lo) begin
      failures++;
      $display("FAIL clamp_lo: val=%0d required %0d", bus.submit_value, exp_lo);
    end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_reset_mid_run;
    test_backpressure;
    test_restart;
    test_error;
    test_clamp;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
